// File: rtl/fpu_addsub_seq.sv
// Multi-cycle single-precision ADD.S/SUB.S sequencer with truncating datapath.
// Ports: clk, rst, start/op/a/b/dst_in request; busy, done, result, dst reply.
module fpu_addsub_seq #(
  parameter int RegAddrWidth = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    op,
  input  logic [31:0]             a,
  input  logic [31:0]             b,
  input  logic [RegAddrWidth-1:0] dst_in,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             result,
  output logic [RegAddrWidth-1:0] dst
);

  typedef enum logic [2:0] {
    IDLE, CMP, ALIGN, OPER, NORM, DONE
  } state_t;

  state_t state, nxt;

  logic [31:0]             op_a, op_b;
  logic [RegAddrWidth-1:0] dst_lat;
  logic                    gt_s, eff_sub;
  logic [7:0]              gt_e, e_dif;
  logic [23:0]             gt_x, lt_x;
  logic [24:0]             sum;

  logic        sa, sb;
  logic [7:0]  ea, eb, exp_inc;
  logic [22:0] ma, mb;
  logic        a_nan, b_nan, a_inf, b_inf, a_ge;

  // Exponent zero means zero: denormal mantissas are flushed here.
  assign sa = op_a[31];
  assign sb = op_b[31];
  assign ea = op_a[30:23];
  assign eb = op_b[30:23];
  assign ma = (ea == 8'd0) ? 23'd0 : op_a[22:0];
  assign mb = (eb == 8'd0) ? 23'd0 : op_b[22:0];
  assign a_nan = (ea == 8'hFF) && (ma != 23'd0);
  assign b_nan = (eb == 8'hFF) && (mb != 23'd0);
  assign a_inf = (ea == 8'hFF) && (ma == 23'd0);
  assign b_inf = (eb == 8'hFF) && (mb == 23'd0);
  assign a_ge = {ea, ma} >= {eb, mb};
  assign exp_inc = gt_e + 8'd1;

  logic        res_load;
  logic [31:0] res_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    res_load = 1'b0;
    res_val  = result;
    unique case (state)
      IDLE: if (start) nxt = CMP;
      CMP: begin
        nxt = ALIGN;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
          nxt      = DONE;
          res_load = 1'b1;
          res_val  = 32'h7FC0_0000;
        end else if (a_inf) begin
          nxt      = DONE;
          res_load = 1'b1;
          res_val  = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
          nxt      = DONE;
          res_load = 1'b1;
          res_val  = {sb, 8'hFF, 23'd0};
        end
      end
      ALIGN: nxt = OPER;
      OPER:  nxt = NORM;
      NORM: begin
        nxt      = DONE;
        res_load = 1'b1;
        if (sum == 25'd0) begin
          res_val = 32'd0;
        end else if (sum[24]) begin
          if (exp_inc == 8'hFF) res_val = {gt_s, 8'hFF, 23'd0};
          else                  res_val = {gt_s, exp_inc, sum[23:1]};
        end else if (sum[23]) begin
          res_val = {gt_s, gt_e, sum[22:0]};
        end else if (gt_e == 8'd1) begin
          res_val = 32'd0;
        end else begin
          nxt      = NORM;
          res_load = 1'b0;
        end
      end
      DONE: nxt = start ? CMP : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      dst_lat <= '0;
      gt_s    <= 1'b0;
      eff_sub <= 1'b0;
      gt_e    <= '0;
      e_dif   <= '0;
      gt_x    <= '0;
      lt_x    <= '0;
      sum     <= '0;
      result  <= '0;
      dst     <= '0;
    end else begin
      if (((state == IDLE) || (state == DONE)) && start) begin
        op_a    <= a;
        op_b    <= {b[31] ^ op, b[30:0]};
        dst_lat <= dst_in;
      end
      unique case (state)
        CMP: begin
          eff_sub <= sa ^ sb;
          if (a_ge) begin
            gt_s  <= sa;
            gt_e  <= ea;
            gt_x  <= {ea != 8'd0, ma};
            lt_x  <= {eb != 8'd0, mb};
            e_dif <= ea - eb;
          end else begin
            gt_s  <= sb;
            gt_e  <= eb;
            gt_x  <= {eb != 8'd0, mb};
            lt_x  <= {ea != 8'd0, ma};
            e_dif <= eb - ea;
          end
        end
        ALIGN:
          lt_x <= (e_dif >= 8'd24) ? 24'd0 : (lt_x >> e_dif);
        OPER:
          sum <= eff_sub ? ({1'b0, gt_x} - {1'b0, lt_x})
                         : ({1'b0, gt_x} + {1'b0, lt_x});
        NORM:
          if (nxt == NORM) begin
            sum  <= {sum[23:0], 1'b0};
            gt_e <= gt_e - 8'd1;
          end
        default: ;
      endcase
      if (res_load) begin
        result <= res_val;
        dst    <= dst_lat;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
